// File: rtl/yaw_heading_tracker_if.sv
// Bus between the receiver/IMU side and the yaw heading tracker, plus debug taps
// (FSM state and tracking register) for checkers and benches.
interface yaw_heading_tracker_if #(
    parameter int REC_WIDTH   = 8,
    parameter int ANGLE_WIDTH = 16,
    parameter int TRACK_SHIFT = 2
);
    // Handshake: a rising edge on start_signal while idle starts one computation;
    // active_signal is high while the result is being built, complete_signal pulses
    // for one cycle when body/error/saturation are valid; they then hold until the
    // next completion. A rising edge while busy is dropped and flagged on start_overrun.
    logic                                 start_signal;
    logic [REC_WIDTH-1:0]                 throttle_pwm_value_input;
    logic [REC_WIDTH-1:0]                 yaw_pwm_value_input;
    logic signed [ANGLE_WIDTH-1:0]        yaw_angle_imu;
    logic [ANGLE_WIDTH-1:0]               body_yaw_angle;
    logic signed [ANGLE_WIDTH-1:0]        yaw_angle_error;
    logic                                 error_saturated;
    logic                                 start_overrun;
    logic                                 active_signal;
    logic                                 complete_signal;
    logic [4:0]                           state_dbg;
    logic signed [ANGLE_WIDTH+TRACK_SHIFT:0] track_dbg;

    modport master (
        output start_signal, throttle_pwm_value_input, yaw_pwm_value_input, yaw_angle_imu,
        input  body_yaw_angle, yaw_angle_error, error_saturated, start_overrun,
               active_signal, complete_signal, state_dbg, track_dbg
    );

    modport slave (
        input  start_signal, throttle_pwm_value_input, yaw_pwm_value_input, yaw_angle_imu,
        output body_yaw_angle, yaw_angle_error, error_saturated, start_overrun,
               active_signal, complete_signal, state_dbg, track_dbg
    );
endinterface

// File: rtl/yaw_heading_tracker.sv
// Integrates the yaw stick into a commanded heading and reports the shortest-path,
// clamped heading error against the IMU yaw. Feeds the yaw-rate PID.
module yaw_heading_tracker #(
    parameter int REC_WIDTH   = 8,
    parameter int ANGLE_WIDTH = 16,
    parameter int ANGLE_FULL  = 5760,
    parameter int TRACK_SHIFT = 2,
    parameter int REC_CENTER  = 125,
    parameter int DEADBAND    = 3,
    parameter int IDLE_THRESH = 10,
    parameter int ERR_LIMIT   = 1440
) (
    input  logic                   us_clk,
    input  logic                   resetn,
    yaw_heading_tracker_if.slave   bus
);
    localparam int TRACK_W = ANGLE_WIDTH + TRACK_SHIFT + 1;
    localparam int DELTA_W = REC_WIDTH + 2;
    localparam int DIFF_W  = ANGLE_WIDTH + 2;

    localparam logic signed [TRACK_W-1:0]     TRACK_FULL = TRACK_W'(ANGLE_FULL * (2 ** TRACK_SHIFT));
    localparam logic signed [ANGLE_WIDTH-1:0] FULL_A     = ANGLE_WIDTH'(ANGLE_FULL);
    localparam logic signed [DIFF_W-1:0]      FULL_D     = DIFF_W'(ANGLE_FULL);
    localparam logic signed [DIFF_W-1:0]      HALF_D     = DIFF_W'(ANGLE_FULL / 2);
    localparam logic signed [DIFF_W-1:0]      LIM_D      = DIFF_W'(ERR_LIMIT);
    localparam logic signed [DELTA_W-1:0]     CENTER_D   = DELTA_W'(REC_CENTER);
    localparam logic signed [DELTA_W-1:0]     DB_D       = DELTA_W'(DEADBAND);
    localparam logic [REC_WIDTH-1:0]          IDLE_R     = REC_WIDTH'(IDLE_THRESH);

    typedef enum logic [4:0] {
        S_WAIT  = 5'b00001,
        S_TRACK = 5'b00010,
        S_BODY  = 5'b00100,
        S_ERROR = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    state_t                        state_q, state_d;
    logic                          start_q;
    logic                          start_rise;
    logic                          idle_l;
    logic [REC_WIDTH-1:0]          yaw_l;
    logic signed [ANGLE_WIDTH-1:0] imu_l;
    logic signed [ANGLE_WIDTH-1:0] imu_norm;
    logic signed [TRACK_W-1:0]     track_q, track_next, track_sum, imu_ext;
    logic signed [DELTA_W-1:0]     delta_raw, delta;
    logic signed [DIFF_W-1:0]      body_ext, imu_d, diff_raw, diff_wrap, err_next;
    logic                          sat_next;
    logic [ANGLE_WIDTH-1:0]        body_q;
    logic signed [ANGLE_WIDTH-1:0] err_q;
    logic                          sat_q, overrun_q, active_q, complete_q;

    assign start_rise = bus.start_signal & ~start_q;

    // One-shot fold of the IMU reading into [0, ANGLE_FULL) for in-range sensors.
    always_comb begin
        imu_norm = bus.yaw_angle_imu;
        if (bus.yaw_angle_imu < 0)
            imu_norm = bus.yaw_angle_imu + FULL_A;
        else if (bus.yaw_angle_imu >= FULL_A)
            imu_norm = bus.yaw_angle_imu - FULL_A;
    end

    always_comb begin
        delta_raw = $signed({2'b00, yaw_l}) - CENTER_D;
        delta     = delta_raw;
        if (delta_raw <= DB_D && delta_raw >= -DB_D)
            delta = '0;
        imu_ext   = $signed({{(TRACK_W-ANGLE_WIDTH){imu_l[ANGLE_WIDTH-1]}}, imu_l});
        track_sum = track_q + $signed({{(TRACK_W-DELTA_W){delta[DELTA_W-1]}}, delta});
        if (idle_l)
            track_next = imu_ext <<< TRACK_SHIFT;
        else if (track_sum >= TRACK_FULL)
            track_next = track_sum - TRACK_FULL;
        else if (track_sum < 0)
            track_next = track_sum + TRACK_FULL;
        else
            track_next = track_sum;
    end

    // Shortest-path error: wrap into [-FULL/2, FULL/2), then clamp to the PID range.
    always_comb begin
        body_ext = $signed({{(DIFF_W-ANGLE_WIDTH){1'b0}}, body_q});
        imu_d    = $signed({{(DIFF_W-ANGLE_WIDTH){imu_l[ANGLE_WIDTH-1]}}, imu_l});
        diff_raw = body_ext - imu_d;
        if (diff_raw >= HALF_D)
            diff_wrap = diff_raw - FULL_D;
        else if (diff_raw < -HALF_D)
            diff_wrap = diff_raw + FULL_D;
        else
            diff_wrap = diff_raw;
        err_next = diff_wrap;
        sat_next = 1'b0;
        if (idle_l) begin
            err_next = '0;
        end else if (diff_wrap > LIM_D) begin
            err_next = LIM_D;
            sat_next = 1'b1;
        end else if (diff_wrap < -LIM_D) begin
            err_next = -LIM_D;
            sat_next = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:  if (start_rise) state_d = S_TRACK;
            S_TRACK: state_d = S_BODY;
            S_BODY:  state_d = S_ERROR;
            S_ERROR: state_d = S_DONE;
            S_DONE:  state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_WAIT;
            start_q    <= 1'b0;
            idle_l     <= 1'b0;
            yaw_l      <= '0;
            imu_l      <= '0;
            track_q    <= '0;
            body_q     <= '0;
            err_q      <= '0;
            sat_q      <= 1'b0;
            overrun_q  <= 1'b0;
            active_q   <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= bus.start_signal;
            overrun_q  <= start_rise && (state_q != S_WAIT);
            active_q   <= (state_q == S_TRACK) || (state_q == S_BODY) || (state_q == S_ERROR);
            complete_q <= (state_q == S_DONE);
            case (state_q)
                S_WAIT: begin
                    if (start_rise) begin
                        idle_l <= (bus.throttle_pwm_value_input < IDLE_R);
                        yaw_l  <= bus.yaw_pwm_value_input;
                        imu_l  <= imu_norm;
                    end
                end
                S_TRACK: track_q <= track_next;
                S_BODY:  body_q  <= idle_l ? imu_l : track_q[TRACK_SHIFT +: ANGLE_WIDTH];
                S_ERROR: begin
                    err_q <= err_next[ANGLE_WIDTH-1:0];
                    sat_q <= sat_next;
                end
                default: ;
            endcase
        end
    end

    assign bus.body_yaw_angle  = body_q;
    assign bus.yaw_angle_error = err_q;
    assign bus.error_saturated = sat_q;
    assign bus.start_overrun   = overrun_q;
    assign bus.active_signal   = active_q;
    assign bus.complete_signal = complete_q;
    assign bus.state_dbg       = state_q;
    assign bus.track_dbg       = track_q;
endmodule
